// File: rtl/pipe_pkg.sv
// pipe_pkg: shared control-bit positions, default widths and the EX/MEM payload layout.
package pipe_pkg;
  localparam int CTRL_MEM_READ   = 0;
  localparam int CTRL_MEM_WRITE  = 1;
  localparam int CTRL_MEM_TO_REG = 2;
  localparam int DATA_W = 32;
  localparam int RD_W   = 5;
  localparam int CTRL_W = 3;
  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] store_data;
    logic [RD_W-1:0]   rd;
  } ex_mem_payload_t;
endpackage

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: 2-entry skid register (main + skid) with registered in_ready and synchronous flush.
module pipe_skid_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);
  logic [WIDTH-1:0] skid_data;
  logic skid_valid, accept, advance;
  // in_ready is the stored state; the skid is occupied exactly when it is low
  assign skid_valid = !in_ready;
  assign accept     = in_valid && in_ready;
  assign advance    = !out_valid || out_ready;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      out_data  <= '0;
      skid_data <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else if (advance) begin
      if (skid_valid) begin
        out_data  <= skid_data;
        out_valid <= 1'b1;
        in_ready  <= 1'b1;
      end else begin
        out_data  <= accept ? in_data : out_data;
        out_valid <= accept;
      end
    end else if (accept) begin
      skid_data <= in_data;
      in_ready  <= 1'b0;
    end
  end
endmodule

// File: rtl/ex_mem_pipe_stage.sv
// ex_mem_pipe_stage: EX/MEM handshake stage with skid buffer and bubble-gated control.
// Define EX_MEM_STALL_CNT_EN to add the saturating stall_cnt output.
module ex_mem_pipe_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W = pipe_pkg::DATA_W,
  parameter int RD_W   = pipe_pkg::RD_W,
  parameter int CTRL_W = pipe_pkg::CTRL_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [DATA_W-1:0] in_store_data,
  input  logic [RD_W-1:0]   in_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_alu_result,
  output logic [DATA_W-1:0] out_store_data,
  output logic [RD_W-1:0]   out_rd
`ifdef EX_MEM_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cnt
`endif
);
  localparam int W = CTRL_W + 2 * DATA_W + RD_W;
  logic [W-1:0] main_data;
  logic [CTRL_W-1:0] main_ctrl;
  pipe_skid_reg #(.WIDTH(W)) u_skid (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   ({in_ctrl, in_alu_result, in_store_data, in_rd}),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (main_data)
  );
  assign {main_ctrl, out_alu_result, out_store_data, out_rd} = main_data;
  // a bubble must never present mem_read/mem_write to the memory stage
  assign out_ctrl = main_ctrl & {CTRL_W{out_valid}};
`ifdef EX_MEM_STALL_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) stall_cnt <= '0;
    else if (out_valid && !out_ready && ~&stall_cnt) stall_cnt <= stall_cnt + 32'd1;
  end
`endif
endmodule

// File: tb/tb_ex_mem_pipe_stage.sv
// tb_ex_mem_pipe_stage: directed vectors with a FIFO scoreboard checked by an independent monitor.
module tb_ex_mem_pipe_stage;
  localparam int DW = 32, RW = 5, CW = 3;
  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] a;
    logic [DW-1:0] s;
    logic [RW-1:0] r;
  } item_t;
  logic clk = 0, reset = 1, flush = 0, in_valid = 0, out_ready = 0;
  logic [CW-1:0] in_ctrl = '0;
  logic [DW-1:0] in_alu_result = '0, in_store_data = '0;
  logic [RW-1:0] in_rd = '0;
  logic in_ready, out_valid;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_alu_result, out_store_data;
  logic [RW-1:0] out_rd;
`ifdef EX_MEM_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif
  item_t exp_q[$];
  int n_chk = 0, n_fail = 0;

  ex_mem_pipe_stage dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl),
    .in_alu_result(in_alu_result), .in_store_data(in_store_data), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
    .out_alu_result(out_alu_result), .out_store_data(out_store_data), .out_rd(out_rd)
`ifdef EX_MEM_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [CW-1:0] c, input logic [DW-1:0] a, input logic [DW-1:0] s,
                      input logic [RW-1:0] r);
    in_valid = 1; in_ctrl = c; in_alu_result = a; in_store_data = s; in_rd = r;
    if (in_ready && !flush) exp_q.push_back('{c, a, s, r});
    tick();
  endtask

  task automatic idle(input int n);
    in_valid = 0;
    repeat (n) tick();
  endtask

  // monitor: every issue must match the oldest outstanding expected entry
  always @(negedge clk) begin
    if (reset) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL issue_unexpected: got rd=%0d alu=%0h expected no issue", out_rd, out_alu_result);
        end else begin
          item_t e;
          e = exp_q.pop_front();
          chk("issue_payload", {out_ctrl, out_alu_result, out_store_data, out_rd}, e);
        end
      end
      if (!out_valid) chk("bubble_ctrl", out_ctrl, 0);
      if (flush) exp_q.delete();
    end
  end

  initial begin
    #1 reset = 0;
    tick(); tick();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_ctrl", out_ctrl, 0);
    reset = 1;
    // latency and bubble with stale data
    out_ready = 1;
    send(3'b001, 32'h5, 32'h6, 5'd1);
    chk("lat_valid", out_valid, 1);
    chk("lat_rd", out_rd, 1);
    chk("lat_ctrl", out_ctrl, 3'b001);
    idle(1);
    chk("bubble_valid", out_valid, 0);
    chk("bubble_ctrl0", out_ctrl, 0);
    chk("bubble_stale_alu", out_alu_result, 32'h5);
    // streaming at full rate
    for (int i = 1; i <= 4; i++) begin
      send(3'b100, 32'(i * 16), 32'(i), 5'(i + 16));
      chk("stream_valid", out_valid, 1);
      chk("stream_alu", out_alu_result, 32'(i * 16));
      chk("stream_in_ready", in_ready, 1);
    end
    idle(1);
    chk("stream_end_valid", out_valid, 0);
    // backpressure fills main then skid
    out_ready = 0;
    send(3'b001, 32'h100, 32'h0, 5'd3);
    chk("bp_ready_after1", in_ready, 1);
    send(3'b001, 32'h200, 32'h0, 5'd7);
    chk("bp_ready_after2", in_ready, 0);
    chk("bp_main_rd", out_rd, 3);
    idle(1);
    chk("bp_hold_ready", in_ready, 0);
    chk("bp_hold_rd", out_rd, 3);
    out_ready = 1;
    tick();
    chk("bp_skid_to_main", out_rd, 7);
    chk("bp_ready_back", in_ready, 1);
    tick();
    chk("bp_drained", out_valid, 0);
    // flush with both entries full, issuing in the same cycle
    out_ready = 0;
    send(3'b010, 32'h300, 32'hAA, 5'd9);
    send(3'b010, 32'h400, 32'hBB, 5'd10);
    chk("fl_full", in_ready, 0);
    flush = 1; out_ready = 1;
    send(3'b010, 32'h500, 32'hCC, 5'd12);
    flush = 0; in_valid = 0;
    chk("fl_valid", out_valid, 0);
    chk("fl_ctrl", out_ctrl, 0);
    chk("fl_ready", in_ready, 1);
    // accept offered during flush is discarded
    out_ready = 0;
    send(3'b001, 32'h600, 32'h0, 5'd11);
    flush = 1;
    send(3'b001, 32'h700, 32'h0, 5'd13);
    flush = 0;
    idle(1);
    out_ready = 1;
    idle(2);
    chk("fl_discard_valid", out_valid, 0);
    // asynchronous reset mid-stall
    out_ready = 0;
    send(3'b011, 32'h800, 32'h1, 5'd14);
    idle(1);
    chk("ar_pre_valid", out_valid, 1);
    #2 reset = 0;
    #1;
    chk("ar_valid", out_valid, 0);
    chk("ar_ctrl", out_ctrl, 0);
    chk("ar_ready", in_ready, 1);
    exp_q.delete();
    #2 reset = 1;
    out_ready = 1;
    tick();
    send(3'b001, 32'h900, 32'h2, 5'd15);
    chk("ar_resume_rd", out_rd, 15);
    chk("ar_resume_valid", out_valid, 1);
    idle(1);
`ifdef EX_MEM_STALL_CNT_EN
    reset = 0; #1 reset = 1;
    exp_q.delete();
    chk("sc_reset", stall_cnt, 0);
    out_ready = 0;
    send(3'b001, 32'hA00, 32'h0, 5'd16);
    idle(5);
    chk("sc_five", stall_cnt, 5);
    flush = 1; out_ready = 1;
    tick();
    flush = 0;
    chk("sc_after_flush", stall_cnt, 5);
    reset = 0; #1;
    chk("sc_after_reset", stall_cnt, 0);
    reset = 1;
    exp_q.delete();
`endif
    out_ready = 1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    chk("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/ex_mem_pipe_stage.md
Name: ex_mem_pipe_stage

Overview:
- Parametrised EX/MEM pipeline stage; successor to the fixed EX/MEM register.
- Adds a valid/ready handshake, a 2-entry skid buffer (full throughput, registered in_ready), synchronous flush, and bubble-safe control outputs.
- Sits between the Execute stage and the data-memory stage.
- Control-field widths are generic so the same block serves later stages.

Parameters:
- DATA_W, 32, width of alu_result and store_data.
- RD_W, 5, destination register index width.
- CTRL_W, 3, control bus width; bit order [0]=mem_read, [1]=mem_write, [2]=mem_to_reg, higher bits user-defined.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low (0 = reset).
- flush  in  1  synchronous kill of all held entries.
- in_valid  in  1  EX presents an instruction.
- in_ready  out  1  stage can accept; registered.
- in_ctrl  in  CTRL_W  control bits.
- in_alu_result  in  DATA_W  ALU result / address.
- in_store_data  in  DATA_W  rs2 data for stores.
- in_rd  in  RD_W  destination register.
- out_valid  out  1  MEM-side entry valid.
- out_ready  in  1  MEM accepts this cycle.
- out_ctrl  out  CTRL_W  control bits, gated by out_valid.
- out_alu_result  out  DATA_W  held payload.
- out_store_data  out  DATA_W  held payload.
- out_rd  out  RD_W  held payload.

Behaviour:
- Handshake definitions:
  - Accept: in_valid && in_ready.
  - Issue: out_valid && out_ready.
  - Payload held stable while out_valid && !out_ready.
- Storage: main register (drives outputs) plus one skid register (skid_valid + payload). in_ready = !skid_valid, taken directly from a flop.
- Latency: 1 cycle from accept to out_valid when the skid is empty.
- Next-state rules, evaluated at the clock edge, in priority order:
  1. reset low (async): out_valid=0, skid_valid=0, all payload regs=0, so in_ready=1 and out_ctrl=0.
  2. flush=1: out_valid=0, skid_valid=0. An accept in the same cycle is discarded. Payload regs may keep their values. in_ready=1 next cycle.
  3. Main empty or issuing:
     - skid_valid: main <= skid, skid_valid <= 0. An accept in the same cycle is impossible, because in_ready was 0.
     - else if accept: main <= input, out_valid <= 1.
     - else: out_valid <= 0.
  4. Main holding (out_valid && !out_ready):
     - accept: skid <= input, skid_valid <= 1, so in_ready drops next cycle.
     - else: no change.
- out_ctrl = main_ctrl & {CTRL_W{out_valid}}. A bubble never asserts mem_read/mem_write. Data outputs are not gated.
- Ordering: strict FIFO. The skid entry always issues after the main entry.
- Occupancy never exceeds 2. No overflow path exists because in_ready=0 when the skid is full.
- Reset deasserting mid-stall: resumes empty. No partial entries.
- Simultaneous flush and out_ready: flush wins. The issued entry still counts as consumed by MEM in that cycle.

Optional Feature:
- Macro EX_MEM_STALL_CNT_EN.
- Defined:
  - Adds output port stall_cnt [31:0], which increments each cycle out_valid && !out_ready.
  - Saturates at 32'hFFFFFFFF.
  - Cleared by reset only; flush does not clear it.
- Undefined: port and counter absent. Behaviour otherwise identical.

Decomposition:
- Package pipe_pkg holds:
  - Localparams CTRL_MEM_READ=0, CTRL_MEM_WRITE=1, CTRL_MEM_TO_REG=2.
  - Default widths DATA_W=32, RD_W=5.
  - Packed struct ex_mem_payload_t {ctrl, alu_result, store_data, rd}.
- One natural sub-module, pipe_skid_reg:
  - Generic WIDTH-bit 2-entry skid register with valid/ready/flush.
  - ex_mem_pipe_stage instantiates it on the concatenated payload and adds out_ctrl gating and the optional counter.

Test Plan:
- Reset low mid-stream with out_valid=1 → out_valid=0, out_ctrl=0, in_ready=1 immediately (async). After release, first accept appears 1 cycle later.
- Streaming: out_ready=1; in_valid=1 for 4 cycles with alu_result 0x10,0x20,0x30,0x40 → out_valid 1 cycle later, same order, in_ready stays 1, zero bubbles.
- Backpressure: out_ready=0; send rd=3 then rd=7 → in_ready=0 from the cycle after the 2nd accept. Raise out_ready → rd=3 then rd=7 issue, and in_ready=1 the cycle after rd=7 moves to main.
- Flush with both entries full (ctrl=3'b010 store) → next cycle out_valid=0, out_ctrl=0, in_ready=1. Data accepted in the flush cycle never appears.
- Bubble: in_valid=0 with main previously holding ctrl=3'b001 and now issued → out_ctrl=0 although data regs retain stale values.
- With EX_MEM_STALL_CNT_EN: hold out_ready=0 for 5 cycles with out_valid=1 → stall_cnt=5; flush → still 5; reset → 0.
